// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM stage load/store unit: bus widths,
// load/store sub-op codes, LSU state encoding and small op decoders.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;

  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'hE0;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'hE1;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'hE3;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'hE4;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'hE5;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'hE8;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'hE9;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'hEB;
  localparam logic [AluOpBus-1:0] EXE_LL_OP  = 8'hF0;
  localparam logic [AluOpBus-1:0] EXE_SC_OP  = 8'hF8;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} lsu_state_e;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_e;

  // Access width of a sub-op; SZ_NONE marks a non-memory instruction.
  function automatic lsu_size_e op_size(input logic [AluOpBus-1:0] op);
    op_size = SZ_NONE;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:            op_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:            op_size = SZ_HALF;
      EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP:  op_size = SZ_WORD;
      default:                                     op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [AluOpBus-1:0] op);
    is_store_op = (op == EXE_SB_OP) || (op == EXE_SH_OP) ||
                  (op == EXE_SW_OP) || (op == EXE_SC_OP);
  endfunction

  function automatic logic is_signed_load(input logic [AluOpBus-1:0] op);
    is_signed_load = (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Big-endian byte-lane steering: lane enables, store-data replication and
// load-data extraction with sign/zero extension. Purely combinational.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop,
  input  logic [1:0]          addr_lo,
  input  logic [RegBus-1:0]   store_src,
  input  logic [RegBus-1:0]   load_word,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   store_data,
  output logic [RegBus-1:0]   load_data
);

  lsu_size_e   size;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane 0 is bits 31:24, so lower addresses map to more significant bytes.
  always_comb begin
    size       = op_size(aluop);
    sel        = 4'b0000;
    store_data = store_src;
    load_data  = load_word;
    byte_val   = 8'h00;
    half_val   = 16'h0000;
    case (size)
      SZ_BYTE: begin
        sel        = 4'b1000 >> addr_lo;
        store_data = {4{store_src[7:0]}};
        case (addr_lo)
          2'b00:   byte_val = load_word[31:24];
          2'b01:   byte_val = load_word[23:16];
          2'b10:   byte_val = load_word[15:8];
          default: byte_val = load_word[7:0];
        endcase
        load_data = is_signed_load(aluop) ? {{24{byte_val[7]}}, byte_val}
                                          : {24'h000000, byte_val};
      end
      SZ_HALF: begin
        sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
        store_data = {2{store_src[15:0]}};
        half_val   = addr_lo[1] ? load_word[15:0] : load_word[31:16];
        load_data  = is_signed_load(aluop) ? {{16{half_val[15]}}, half_val}
                                           : {16'h0000, half_val};
      end
      SZ_WORD: sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: runs one req/ack bus transaction per memory op,
// stalls the pipeline until acknowledged, and keeps the LL/SC link bit.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [RegBus-1:0]     mem_hi,
  input  logic [RegBus-1:0]     mem_lo,
  input  logic                  mem_whilo,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [RegBus-1:0]     mem_mem_addr,
  input  logic [RegBus-1:0]     mem_reg2,
  input  logic                  mem_cp0_reg_we,
  input  logic [4:0]            mem_cp0_reg_write_addr,
  input  logic [RegBus-1:0]     mem_cp0_reg_data,
  input  logic [RegBus-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [RegBus-1:0]     bus_addr,
  output logic [3:0]            bus_sel,
  output logic [RegBus-1:0]     bus_wdata,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [RegBus-1:0]     wb_wdata,
  output logic [RegBus-1:0]     wb_hi,
  output logic [RegBus-1:0]     wb_lo,
  output logic                  wb_whilo,
  output logic                  wb_cp0_reg_we,
  output logic [4:0]            wb_cp0_reg_write_addr,
  output logic [RegBus-1:0]     wb_cp0_reg_data,
  output logic                  stallreq,
  output logic                  exc_misaligned,
  output logic                  llbit_o
);

  lsu_state_e        state, state_next;
  logic              llbit;
  logic [RegBus-1:0] rdata_q;
  logic              capture;
  logic              drive_bus;
  lsu_size_e         size;
  logic              is_mem, is_store, is_ll, is_sc, misaligned, sc_fail, go;
  logic [3:0]        lane_sel;
  logic [RegBus-1:0] store_data, load_data;

  assign size       = op_size(mem_aluop);
  assign is_mem     = (size != SZ_NONE);
  assign is_store   = is_store_op(mem_aluop);
  assign is_ll      = (mem_aluop == EXE_LL_OP);
  assign is_sc      = (mem_aluop == EXE_SC_OP);
  assign misaligned = ((size == SZ_HALF) && mem_mem_addr[0]) ||
                      ((size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00));
  assign sc_fail    = is_sc && !llbit;
  assign go         = is_mem && !misaligned && !sc_fail;

  mem_lsu_align u_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_mem_addr[1:0]),
    .store_src  (mem_reg2),
    .load_word  (rdata_q),
    .sel        (lane_sel),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // Bus fields are only driven while a request is outstanding; the EX/MEM
  // register is frozen by stallreq, so they stay stable through WAIT.
  assign bus_req   = drive_bus;
  assign bus_we    = drive_bus && is_store;
  assign bus_addr  = drive_bus ? {mem_mem_addr[31:2], 2'b00} : '0;
  assign bus_sel   = drive_bus ? lane_sel : 4'b0000;
  assign bus_wdata = (drive_bus && is_store) ? store_data : '0;

  // Next-state and MEM/WB field selection; reset and flush emit a NOP.
  always_comb begin
    state_next            = state;
    drive_bus             = 1'b0;
    capture               = 1'b0;
    stallreq              = 1'b0;
    exc_misaligned        = 1'b0;
    llbit_o               = llbit;
    wb_wd                 = mem_wd;
    wb_wreg               = mem_wreg;
    wb_wdata              = mem_wdata;
    wb_hi                 = mem_hi;
    wb_lo                 = mem_lo;
    wb_whilo              = mem_whilo;
    wb_cp0_reg_we         = mem_cp0_reg_we;
    wb_cp0_reg_write_addr = mem_cp0_reg_write_addr;
    wb_cp0_reg_data       = mem_cp0_reg_data;
    if (rst || flush) begin
      state_next            = IDLE;
      wb_wd                 = '0;
      wb_wreg               = 1'b0;
      wb_wdata              = '0;
      wb_hi                 = '0;
      wb_lo                 = '0;
      wb_whilo              = 1'b0;
      wb_cp0_reg_we         = 1'b0;
      wb_cp0_reg_write_addr = '0;
      wb_cp0_reg_data       = '0;
      if (rst) llbit_o = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem && misaligned) begin
            exc_misaligned = 1'b1;
            wb_wreg        = 1'b0;
          end else if (sc_fail) begin
            wb_wreg  = 1'b1;
            wb_wdata = '0;
          end else if (go) begin
            drive_bus = 1'b1;
            stallreq  = 1'b1;
            wb_wreg   = 1'b0;
            if (bus_ack) begin
              capture    = 1'b1;
              state_next = DONE;
            end else begin
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          drive_bus = 1'b1;
          stallreq  = 1'b1;
          wb_wreg   = 1'b0;
          if (bus_ack) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
          if (is_sc) begin
            wb_wreg  = 1'b1;
            wb_wdata = 32'd1;
          end else if (!is_store) begin
            wb_wdata = load_data;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, captured read data and link bit; LL/SC update the link on entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      llbit   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        llbit <= 1'b0;
      end else if (capture) begin
        if (is_ll)      llbit <= 1'b1;
        else if (is_sc) llbit <= 1'b0;
      end
      if (capture) rdata_q <= bus_rdata;
    end
  end

endmodule
